// File: rtl/timer_pkg.sv
// Shared encodings, field widths and count helpers for the countdown timer.
package timer_pkg;

    localparam int unsigned MSEC_W  = 7;
    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned STATE_W = 2;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COUNT   = 2'd1;
    localparam logic [1:0] EXPIRED = 2'd2;

    localparam logic [MSEC_W-1:0] CS_MAX  = MSEC_W'(99);
    localparam logic [SEC_W-1:0]  SEC_MAX = SEC_W'(59);

    // MM:SS.cc count value as held by the datapath.
    typedef struct packed {
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [MSEC_W-1:0] msec;
    } count_t;

    // True when the count reads 00:00.00.
    function automatic logic is_zero(input count_t c);
        return (c.min == '0) && (c.sec == '0) && (c.msec == '0);
    endfunction

    // One-centisecond decrement with borrow through seconds into minutes.
    function automatic count_t dec_cs(input count_t c);
        count_t r;
        r = c;
        if (c.msec != '0) begin
            r.msec = c.msec - MSEC_W'(1);
        end else begin
            r.msec = CS_MAX;
            if (c.sec != '0) begin
                r.sec = c.sec - SEC_W'(1);
            end else begin
                r.sec = SEC_MAX;
                r.min = c.min - MIN_W'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing one 10 ms tick per TICK_DIV clocks while enabled.
// tick is decoded from the prescaler so the count updates on the same edge
// the prescaler wraps, giving exactly TICK_DIV clocks from enable to first tick.
module tick_gen #(
    parameter int unsigned TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = en && !sync_clr && (cnt_q == CNT_LAST);

    // Prescaler: held at zero unless enabled, wraps after TICK_DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (sync_clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/timer_datapath.sv
// Countdown-timer datapath: adjusts MM:SS.cc while stopped, counts down at
// 100 Hz while running, and flags expiry.
module timer_datapath
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1_000_000,
    parameter int unsigned MAX_MIN  = 59
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_stop,
    input  logic              clear,
    input  logic              inc,
    input  logic              dec,
    output logic [MSEC_W-1:0] msec,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic              running,
    output logic              done,
    output logic              alarm
);

    localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MAX_MIN);

    logic [STATE_W-1:0] state_q, state_d;
    count_t             cnt_q, cnt_d;
    logic               done_d;
    logic               running_q, done_q, alarm_q;
    logic               tick, tick_en, tick_clr;

    // Prescaler only advances in COUNT with run_stop held; any exit restarts it.
    assign tick_clr = clear || !((state_q == COUNT) && run_stop);
    assign tick_en  = !tick_clr;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (tick_en),
        .sync_clr (tick_clr),
        .tick     (tick)
    );

    // Next state, next count and done pulse; priority clear > inc > dec > tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inc) begin
                        if (!((cnt_q.min == MIN_TOP) && (cnt_q.sec == SEC_MAX))) begin
                            if (cnt_q.sec == SEC_MAX) begin
                                cnt_d.sec = '0;
                                cnt_d.min = cnt_q.min + MIN_W'(1);
                            end else begin
                                cnt_d.sec = cnt_q.sec + SEC_W'(1);
                            end
                        end
                    end else if (dec) begin
                        if (!((cnt_q.min == '0) && (cnt_q.sec == '0))) begin
                            if (cnt_q.sec == '0) begin
                                cnt_d.sec = SEC_MAX;
                                cnt_d.min = cnt_q.min - MIN_W'(1);
                            end else begin
                                cnt_d.sec = cnt_q.sec - SEC_W'(1);
                            end
                        end
                    end
                    // Start only from a non-zero value, judged after any adjust.
                    if (run_stop && !is_zero(cnt_d)) begin
                        state_d = COUNT;
                    end
                end
                COUNT: begin
                    if (!run_stop) begin
                        state_d = IDLE;
                    end else if (tick) begin
                        cnt_d = dec_cs(cnt_q);
                        if (is_zero(cnt_d)) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    if (!run_stop) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, count and status flags; async reset returns everything to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            running_q <= (state_d == COUNT);
            done_q    <= done_d;
            alarm_q   <= (state_d == EXPIRED);
        end
    end

    assign msec    = cnt_q.msec;
    assign sec     = cnt_q.sec;
    assign min     = cnt_q.min;
    assign running = running_q;
    assign done    = done_q;
    assign alarm   = alarm_q;

endmodule

// File: tb/tb_timer_datapath.sv
// Scoreboard bench for timer_datapath with TICK_DIV=4: stimulus queues the
// expected snapshot for the cycle just clocked, a negedge monitor compares.
module tb_timer_datapath;

    localparam int unsigned TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_stop = 1'b0;
    logic       clear = 1'b0;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic       running;
    logic       done;
    logic       alarm;

    timer_datapath #(.TICK_DIV(TD), .MAX_MIN(59)) dut (
        .clk      (clk),
        .rst      (rst),
        .run_stop (run_stop),
        .clear    (clear),
        .inc      (inc),
        .dec      (dec),
        .msec     (msec),
        .sec      (sec),
        .min      (min),
        .running  (running),
        .done     (done),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        string       nm;
        int          m;
        int          s;
        int          ms;
        logic        r;
        logic        d;
        logic        a;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   n_vec = 0;
    int   n_err = 0;

    // Monitor: compare every expectation queued for the cycle now on the outputs.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            me = sb.pop_front();
            n_vec++;
            if (min !== 6'(me.m) || sec !== 6'(me.s) || msec !== 7'(me.ms) ||
                running !== me.r || done !== me.d || alarm !== me.a) begin
                n_err++;
                $display("FAIL %s @cyc %0d: got %0d:%0d.%0d run=%b done=%b alarm=%b, want %0d:%0d.%0d run=%b done=%b alarm=%b",
                         me.nm, cyc, min, sec, msec, running, done, alarm,
                         me.m, me.s, me.ms, me.r, me.d, me.a);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int m, input int s, input int ms,
                       input logic r, input logic d, input logic a);
        exp_t e;
        e.cyc = cyc;
        e.nm  = nm;
        e.m   = m;
        e.s   = s;
        e.ms  = ms;
        e.r   = r;
        e.d   = d;
        e.a   = a;
        sb.push_back(e);
    endtask

    task automatic pulse_inc();
        inc = 1'b1;
        step();
        inc = 1'b0;
    endtask

    task automatic pulse_dec();
        dec = 1'b1;
        step();
        dec = 1'b0;
    endtask

    // Clear to zero, then inc n seconds with idle gaps between pulses.
    task automatic preload(input int n);
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < n; i++) begin
            pulse_inc();
            step();
        end
    endtask

    // Count down exactly k ticks, then stop.
    task automatic run_ticks(input int k);
        run_stop = 1'b1;
        repeat (1 + TD * k) step();
        run_stop = 1'b0;
        step();
    endtask

    initial begin
        step();
        chk("reset_held", 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        step();
        chk("reset_released", 0, 0, 0, 0, 0, 0);

        // inc x3, then dec x5 saturating at zero
        for (int i = 1; i <= 3; i++) begin
            pulse_inc();
            chk("inc_seq", 0, i, 0, 0, 0, 0);
            step();
        end
        for (int i = 1; i <= 5; i++) begin
            pulse_dec();
            chk("dec_seq", 0, (3 - i) > 0 ? (3 - i) : 0, 0, 0, 0, 0);
            step();
        end
        run_stop = 1'b1;
        step();
        chk("start_at_zero", 0, 0, 0, 0, 0, 0);
        step();
        chk("start_at_zero_hold", 0, 0, 0, 0, 0, 0);
        run_stop = 1'b0;

        // seconds carry and 59:59 saturation
        preload(59);
        chk("preload_0059", 0, 59, 0, 0, 0, 0);
        pulse_inc();
        chk("inc_carry", 1, 0, 0, 0, 0, 0);
        preload(3599);
        chk("preload_5959", 59, 59, 0, 0, 0, 0);
        pulse_inc();
        chk("inc_saturate", 59, 59, 0, 0, 0, 0);

        // expiry from 00:00.02
        preload(1);
        run_ticks(98);
        chk("preload_0002", 0, 0, 2, 0, 0, 0);
        run_stop = 1'b1;
        step();
        chk("exp_e0", 0, 0, 2, 1, 0, 0);
        step(); chk("exp_e1", 0, 0, 2, 1, 0, 0);
        step(); chk("exp_e2", 0, 0, 2, 1, 0, 0);
        step(); chk("exp_e3", 0, 0, 2, 1, 0, 0);
        step(); chk("exp_e4_tick", 0, 0, 1, 1, 0, 0);
        step(); chk("exp_e5", 0, 0, 1, 1, 0, 0);
        step(); chk("exp_e6", 0, 0, 1, 1, 0, 0);
        step(); chk("exp_e7", 0, 0, 1, 1, 0, 0);
        step(); chk("exp_e8_done", 0, 0, 0, 0, 1, 1);
        step(); chk("exp_e9_done_drop", 0, 0, 0, 0, 0, 1);
        step(); chk("exp_e10_alarm_hold", 0, 0, 0, 0, 0, 1);
        run_stop = 1'b0;
        step();
        chk("alarm_clear_on_stop", 0, 0, 0, 0, 0, 0);

        // borrow across minute, stop/hold, inc ignored while running
        preload(60);
        chk("preload_0100", 1, 0, 0, 0, 0, 0);
        run_stop = 1'b1;
        step();
        chk("brw_e0", 1, 0, 0, 1, 0, 0);
        repeat (3) step();
        chk("brw_e3", 1, 0, 0, 1, 0, 0);
        step();
        chk("brw_first_tick", 0, 59, 99, 1, 0, 0);
        step();
        inc = 1'b1;
        step();
        inc = 1'b0;
        chk("inc_ignored_running", 0, 59, 99, 1, 0, 0);
        step();
        step();
        chk("brw_second_tick", 0, 59, 98, 1, 0, 0);
        run_stop = 1'b0;
        step();
        chk("stop_hold", 0, 59, 98, 0, 0, 0);
        repeat (4) step();
        chk("stop_hold_later", 0, 59, 98, 0, 0, 0);
        pulse_inc();
        chk("inc_after_stop_carry", 1, 0, 98, 0, 0, 0);

        // clear while counting, run_stop left high
        preload(10);
        run_stop = 1'b1;
        repeat (5) step();
        chk("clr_pre_tick", 0, 9, 99, 1, 0, 0);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_mid_count", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("clear_stays_idle", 0, 0, 0, 0, 0, 0);
        end
        run_stop = 1'b0;

        // async reset between clock edges while counting
        preload(5);
        run_stop = 1'b1;
        repeat (5) step();
        chk("rst_pre_tick", 0, 4, 99, 1, 0, 0);
        step();
        #2;
        rst = 1'b1;
        chk("async_reset", 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("after_reset_zero_idle", 0, 0, 0, 0, 0, 0);
        run_stop = 1'b0;
        pulse_inc();
        chk("after_reset_inc", 0, 1, 0, 0, 0, 0);
        run_stop = 1'b1;
        step();
        chk("after_reset_start", 0, 1, 0, 1, 0, 0);
        repeat (4) step();
        chk("after_reset_tick", 0, 0, 99, 1, 0, 0);
        run_stop = 1'b0;
        step();

        repeat (3) step();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
